// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master controller.
// Response encodings and the controller state type.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_RSP
   } state_e;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Transaction watchdog: counts cycles while run_i is high.
// expire_o pulses on the LIMIT-th consecutive running cycle.
module axi_lite_watchdog #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(LIMIT);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = '0;
      if (run_i) count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

   assign expire_o = run_i && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master behind a command/response port.
// Define AXIL_TIMEOUT_EN to abort stalled transactions with SLVERR.
module axi_lite_master_ctrl
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter logic [2:0]  PROT           = 3'b000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic                    CMD_WRITE,
   input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
   input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
   output logic                    RSP_VALID,
   input  logic                    RSP_READY,
   output logic [DATA_WIDTH-1:0]   RSP_RDATA,
   output logic [1:0]              RSP_RESP,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic [2:0]              AWPROT,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic [2:0]              ARPROT,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
      $error("DATA_WIDTH must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_to
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_e                  state_q;
   logic                    cmd_ready_q, rsp_valid_q;
   logic                    awvalid_q, wvalid_q, bready_q;
   logic                    arvalid_q, rready_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic [1:0]              resp_q;
   logic                    expire;
   logic                    aw_ok, w_ok;

`ifdef AXIL_TIMEOUT_EN
   logic wd_run;

   assign wd_run = (state_q != ST_IDLE) && (state_q != ST_RSP);

   axi_lite_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (ACLK),
      .rst_i    (ARESET),
      .run_i    (wd_run),
      .expire_o (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // A channel is finished once its VALID is low or is handshaking now.
   assign aw_ok = !awvalid_q || AWREADY;
   assign w_ok  = !wvalid_q || WREADY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         resp_q      <= '0;
      end else if (expire) begin
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rdata_q     <= '0;
         resp_q      <= RESP_SLVERR;
         rsp_valid_q <= 1'b1;
         state_q     <= ST_RSP;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= CMD_ADDR;
                  if (CMD_WRITE) begin
                     wdata_q   <= CMD_WDATA;
                     wstrb_q   <= CMD_WSTRB;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= ST_WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= ST_RD_REQ;
                  end
               end
            end
            ST_WR_REQ: begin
               if (AWREADY) awvalid_q <= 1'b0;
               if (WREADY)  wvalid_q  <= 1'b0;
               if (aw_ok && w_ok) begin
                  bready_q <= 1'b1;
                  state_q  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (BVALID) begin
                  bready_q    <= 1'b0;
                  resp_q      <= BRESP;
                  rdata_q     <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RSP;
               end
            end
            ST_RD_REQ: begin
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (RVALID) begin
                  rready_q    <= 1'b0;
                  rdata_q     <= RDATA;
                  resp_q      <= RRESP;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (RSP_READY) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign CMD_READY = cmd_ready_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rdata_q;
   assign RSP_RESP  = resp_q;
   assign AWADDR    = addr_q;
   assign AWPROT    = PROT;
   assign AWVALID   = awvalid_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign WVALID    = wvalid_q;
   assign BREADY    = bready_q;
   assign ARADDR    = addr_q;
   assign ARPROT    = PROT;
   assign ARVALID   = arvalid_q;
   assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Self-checking bench for axi_lite_master_ctrl with a memory-backed
// AXI-Lite slave of configurable wait states.
module tb_axi_lite_master_ctrl;

   localparam logic [2:0] TPROT = 3'b101;
   localparam int         TO    = 16;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
   logic [31:0] CMD_ADDR = '0, CMD_WDATA = '0;
   logic [3:0]  CMD_WSTRB = '0;
   logic        RSP_VALID, RSP_READY = 1'b0;
   logic [31:0] RSP_RDATA;
   logic [1:0]  RSP_RESP;
   logic [31:0] AWADDR, WDATA, ARADDR;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, AWREADY, WVALID, WREADY;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;
   logic        BVALID, BREADY, ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic        RVALID, RREADY;

   always #5 ACLK = ~ACLK;

   axi_lite_master_ctrl #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .PROT           (TPROT),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .ACLK (ACLK), .ARESET (ARESET),
      .CMD_VALID (CMD_VALID), .CMD_READY (CMD_READY),
      .CMD_WRITE (CMD_WRITE), .CMD_ADDR (CMD_ADDR),
      .CMD_WDATA (CMD_WDATA), .CMD_WSTRB (CMD_WSTRB),
      .RSP_VALID (RSP_VALID), .RSP_READY (RSP_READY),
      .RSP_RDATA (RSP_RDATA), .RSP_RESP (RSP_RESP),
      .AWADDR (AWADDR), .AWPROT (AWPROT),
      .AWVALID (AWVALID), .AWREADY (AWREADY),
      .WDATA (WDATA), .WSTRB (WSTRB),
      .WVALID (WVALID), .WREADY (WREADY),
      .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
      .ARADDR (ARADDR), .ARPROT (ARPROT),
      .ARVALID (ARVALID), .ARREADY (ARREADY),
      .RDATA (RDATA), .RRESP (RRESP),
      .RVALID (RVALID), .RREADY (RREADY)
   );

   // ---------------- slave ----------------
   int          aw_dly = 0, w_dly = 0, b_dly = 0;
   int          ar_dly = 0, r_dly = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic        mem_clr = 1'b1;
   logic [31:0] smem [16];
   logic        aw_got, w_got, ar_got, b_act, r_act;
   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
         s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
         s_araddr <= '0;
      end else begin
         if (AWVALID && AWREADY) begin
            aw_got <= 1'b1; s_awaddr <= AWADDR;
         end
         if (WVALID && WREADY) begin
            w_got <= 1'b1; s_wdata <= WDATA; s_wstrb <= WSTRB;
         end
         if (BVALID && BREADY) begin
            aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (ARVALID && ARREADY) begin
            ar_got <= 1'b1; s_araddr <= ARADDR;
         end
         if (RVALID && RREADY) ar_got <= 1'b0;
      end
   end

   always @(negedge ACLK) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++)
            smem[i] <= (i == 8) ? 32'h1234_5678 : 32'h0;
      end
      if (ARESET) begin
         AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0;
         ARREADY <= 1'b0; RVALID <= 1'b0;
         BRESP <= '0; RRESP <= '0; RDATA <= '0;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         b_cnt <= 0; r_cnt <= 0; b_act <= 1'b0; r_act <= 1'b0;
      end else begin
         AWREADY <= AWVALID && !aw_got && aw_cnt >= aw_dly;
         if (!AWVALID) aw_cnt <= 0;
         else if (!aw_got) aw_cnt <= aw_cnt + 1;
         WREADY <= WVALID && !w_got && w_cnt >= w_dly;
         if (!WVALID) w_cnt <= 0;
         else if (!w_got) w_cnt <= w_cnt + 1;
         if (aw_got && w_got && !b_act) begin
            for (int b = 0; b < 4; b++)
               if (s_wstrb[b])
                  smem[s_awaddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            b_act <= 1'b1; b_cnt <= 1; BRESP <= bresp_cfg;
            BVALID <= (b_dly == 0);
         end else if (b_act && aw_got) begin
            BVALID <= b_cnt >= b_dly; b_cnt <= b_cnt + 1;
         end else begin
            b_act <= 1'b0; BVALID <= 1'b0;
         end
         ARREADY <= ARVALID && !ar_got && ar_cnt >= ar_dly;
         if (!ARVALID) ar_cnt <= 0;
         else if (!ar_got) ar_cnt <= ar_cnt + 1;
         if (ar_got && !r_act) begin
            r_act <= 1'b1; r_cnt <= 1; RRESP <= rresp_cfg;
            RDATA <= smem[s_araddr[5:2]];
            RVALID <= (r_dly == 0);
         end else if (r_act && ar_got) begin
            RVALID <= r_cnt >= r_dly; r_cnt <= r_cnt + 1;
         end else begin
            r_act <= 1'b0; RVALID <= 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   int compared = 0;
   int mismatched = 0;
   logic [31:0] mmem [16];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
      input logic [31:0] nw, input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (old & ~m) | (nw & m);
   endfunction

   task automatic do_txn(input logic wr, input logic [31:0] addr,
      input logic [31:0] data, input logic [3:0] strb, input int hold,
      input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
      input int exp_lat, output int awh, output int wh, output int arh);
      int n, lat;
      awh = 0; wh = 0; arh = 0;
      @(negedge ACLK);
      CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr;
      CMD_WDATA = data; CMD_WSTRB = strb;
      n = 0;
      while (!CMD_READY && n < 100) begin
         @(negedge ACLK); n++;
      end
      chk("cmd_accept", CMD_READY, 1);
      @(negedge ACLK);
      CMD_VALID = 1'b0; CMD_ADDR = $urandom; CMD_WDATA = $urandom;
      CMD_WSTRB = 4'($urandom);
      lat = 1;
      while (!RSP_VALID && lat < 200) begin
         chk("cmd_busy", CMD_READY, 0);
         if (AWVALID) begin
            awh++;
            chk("awaddr", AWADDR, addr);
            chk("awprot", AWPROT, TPROT);
         end
         if (WVALID) begin
            wh++;
            chk("wdata", WDATA, data);
            chk("wstrb", WSTRB, strb);
         end
         if (ARVALID) begin
            arh++;
            chk("araddr", ARADDR, addr);
            chk("arprot", ARPROT, TPROT);
         end
         @(negedge ACLK); lat++;
      end
      chk("rsp_valid", RSP_VALID, 1);
      chk("latency", lat, exp_lat);
      chk("rsp_rdata", RSP_RDATA, exp_rdata);
      chk("rsp_resp", RSP_RESP, exp_resp);
      for (int i = 0; i < hold; i++) begin
         @(negedge ACLK);
         chk("hold_valid", RSP_VALID, 1);
         chk("hold_rdata", RSP_RDATA, exp_rdata);
         chk("hold_resp", RSP_RESP, exp_resp);
         chk("hold_cmd_ready", CMD_READY, 0);
      end
      RSP_READY = 1'b1;
      @(negedge ACLK);
      RSP_READY = 1'b0;
      chk("rsp_done", RSP_VALID, 0);
      chk("cmd_ready_again", CMD_READY, 1);
   endtask

   initial begin
      int awh, wh, arh, n, seen, idx, hold, el;
      logic wr;
      logic [31:0] d;
      logic [3:0] s;
      logic [1:0] rs;

      for (int i = 0; i < 16; i++)
         mmem[i] = (i == 8) ? 32'h1234_5678 : 32'h0;
      repeat (2) @(negedge ACLK);
      mem_clr = 1'b0;
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);

      chk("rst_cmd_ready", CMD_READY, 1);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_valids", {AWVALID, WVALID, ARVALID}, 0);
      chk("rst_readys", {BREADY, RREADY}, 0);
      chk("rst_addr", {AWADDR, ARADDR}, 0);
      chk("rst_wdata", {WSTRB, WDATA}, 0);
      chk("rst_rsp", {RSP_RESP, RSP_RDATA}, 0);

      // zero-wait write
      do_txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 2'b00, 3,
             awh, wh, arh);
      chk("wr0_awh", awh, 1);
      chk("wr0_wh", wh, 1);
      mmem[4] = merge(mmem[4], 32'hDEAD_BEEF, 4'hF);

      // W channel stalled five cycles behind AW
      w_dly = 5; bresp_cfg = 2'b01;
      do_txn(1, 32'h14, 32'hA5A5_0F0F, 4'h5, 0, 32'h0, 2'b01, 8,
             awh, wh, arh);
      chk("wr1_awh", awh, 1);
      chk("wr1_wh", wh, 6);
      mmem[5] = merge(mmem[5], 32'hA5A5_0F0F, 4'h5);
      w_dly = 0; bresp_cfg = 2'b00;

      // read with AR wait states and SLVERR
      ar_dly = 3; rresp_cfg = 2'b10;
      do_txn(0, 32'h20, 32'h0, 4'h0, 0, mmem[8], 2'b10, 6,
             awh, wh, arh);
      chk("rd0_arh", arh, 4);
      ar_dly = 0; rresp_cfg = 2'b00;

      // response back-pressure
      rresp_cfg = 2'b11;
      do_txn(0, 32'h10, 32'h0, 4'h0, 4, mmem[4], 2'b11, 3,
             awh, wh, arh);
      rresp_cfg = 2'b00;

      // reset while waiting for BVALID
      b_dly = 1000;
      @(negedge ACLK);
      CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h30;
      CMD_WDATA = 32'hCAFE_F00D; CMD_WSTRB = 4'hC;
      @(negedge ACLK);
      CMD_VALID = 1'b0;
      n = 0;
      while (!BREADY && n < 50) begin
         @(negedge ACLK); n++;
      end
      chk("rst_mid_bready", BREADY, 1);
      #2 ARESET = 1'b1;
      #1;
      chk("rst_mid_cmd_ready", CMD_READY, 1);
      chk("rst_mid_readys", {BREADY, RREADY}, 0);
      chk("rst_mid_valids", {AWVALID, WVALID, ARVALID, RSP_VALID}, 0);
      chk("rst_mid_payload", {AWADDR, WDATA}, 0);
      mmem[12] = merge(mmem[12], 32'hCAFE_F00D, 4'hC);
      @(negedge ACLK);
      @(negedge ACLK);
      #2 ARESET = 1'b0;
      b_dly = 0;
      seen = 0;
      repeat (8) begin
         @(negedge ACLK);
         if (RSP_VALID) seen++;
      end
      chk("rst_mid_no_rsp", seen, 0);
      chk("rst_mid_idle", CMD_READY, 1);

      // randomized traffic against the memory model
      for (int t = 0; t < 30; t++) begin
         wr = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, 15);
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         rs = 2'($urandom_range(0, 3));
         hold = $urandom_range(0, 2);
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
         b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
         r_dly = $urandom_range(0, 3);
         bresp_cfg = rs; rresp_cfg = rs;
         if (wr) begin
            el = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            do_txn(1, {26'h0, 4'(idx), 2'b00}, d, s, hold, 32'h0, rs,
                   el, awh, wh, arh);
            chk("rnd_awh", awh, aw_dly + 1);
            chk("rnd_wh", wh, w_dly + 1);
            mmem[idx] = merge(mmem[idx], d, s);
         end else begin
            el = 3 + ar_dly + r_dly;
            do_txn(0, {26'h0, 4'(idx), 2'b00}, d, s, hold, mmem[idx],
                   rs, el, awh, wh, arh);
            chk("rnd_arh", arh, ar_dly + 1);
         end
      end
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

`ifdef AXIL_TIMEOUT_EN
      // slave never accepts the read address
      ar_dly = 1000;
      do_txn(0, 32'h24, 32'h0, 4'h0, 0, 32'h0, 2'b10, TO + 1,
             awh, wh, arh);
      chk("to_arh", arh, TO);
      chk("to_arvalid", ARVALID, 0);
      ar_dly = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
